// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Optional KEY_CACHE_EN keeps the last key and its round-10 key to skip the forward expansion.
module inv_cipher_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] cipherIn,
   input  logic [127:0] keyIn,
   output logic         ready,
   output logic         valid,
   output logic [127:0] plainOut
);

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, FINAL} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w1, w2, w3;
      w3 = k[31:0] ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      return {k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0}, w1, w2, w3};
   endfunction

   // Byte r+4c of the state sits at bits [127-8(r+4c) -: 8].
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r)&3)) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] key_q, key_d, data_q, data_d, plain_q, plain_d;
   logic         valid_q, valid_d, ready_q, ready_d;
   logic [127:0] fwd_key, inv_key, add_key;
`ifdef KEY_CACHE_EN
   logic [127:0] cache_key_q, cache_key_d, cache_rk10_q, cache_rk10_d;
   logic         cache_vld_q, cache_vld_d;
`endif

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      data_d  = data_q;
      plain_d = plain_q;
      valid_d = 1'b0;
`ifdef KEY_CACHE_EN
      cache_key_d  = cache_key_q;
      cache_rk10_d = cache_rk10_q;
      cache_vld_d  = cache_vld_q;
`endif
      // key_q holds rk[cnt+1] in ROUND and rk1 in FINAL (cnt=0), so one inverse step yields rk[cnt].
      fwd_key = fwd_step(key_q, rcon(cnt_q));
      inv_key = inv_step(key_q, rcon(cnt_q + 4'd1));
      add_key = inv_shift_sub(data_q) ^ inv_key;

      case (state_q)
         IDLE: if (start) begin
`ifdef KEY_CACHE_EN
            if (cache_vld_q && keyIn == cache_key_q) begin
               key_d   = cache_rk10_q;
               data_d  = cipherIn ^ cache_rk10_q;
               cnt_d   = 4'd9;
               state_d = ROUND;
            end else begin
               key_d       = keyIn;
               data_d      = cipherIn;
               cnt_d       = 4'd1;
               state_d     = KEXP;
               cache_key_d = keyIn;
               cache_vld_d = 1'b0;
            end
`else
            key_d   = keyIn;
            data_d  = cipherIn;
            cnt_d   = 4'd1;
            state_d = KEXP;
`endif
         end
         KEXP: begin
            key_d = fwd_key;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd10) begin
               data_d  = data_q ^ fwd_key;
               cnt_d   = 4'd9;
               state_d = ROUND;
`ifdef KEY_CACHE_EN
               cache_rk10_d = fwd_key;
               cache_vld_d  = 1'b1;
`endif
            end
         end
         ROUND: begin
            key_d  = inv_key;
            data_d = inv_mix_columns(add_key);
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = FINAL;
         end
         FINAL: begin
            plain_d = add_key;
            valid_d = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   // NOTE: sequential state is updated only with non-blocking assignments to avoid read/write races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         key_q   <= '0;
         data_q  <= '0;
         plain_q <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
`ifdef KEY_CACHE_EN
         cache_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         data_q  <= data_d;
         plain_q <= plain_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
`ifdef KEY_CACHE_EN
         cache_vld_q <= cache_vld_d;
`endif
      end
   end

`ifdef KEY_CACHE_EN
   // NOTE: cached key storage has no reset; cache_vld_q alone decides whether it is trusted.
   always_ff @(posedge clk) begin
      cache_key_q  <= cache_key_d;
      cache_rk10_q <= cache_rk10_d;
   end
`endif

   assign ready    = ready_q;
   assign valid    = valid_q;
   assign plainOut = plain_q;

endmodule

// File: doc/inv_cipher_iter.md
INV_CIPHER_ITER -- requirements
Module: inv_cipher_iter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 cipherIn  input  128  ciphertext block, byte 0 in bits [127:120].
REQ-006 keyIn  input  128  AES-128 cipher key, same byte order as cipherIn.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 valid  output  1  one-cycle pulse; plainOut is new.
REQ-009 plainOut  output  128  recovered plaintext; held until the next valid.

Function
REQ-010 The block SHALL implement FIPS-197 AES-128 inverse cipher iteratively, one round per cycle.
REQ-011 FSM states SHALL be IDLE, KEXP, ROUND, FINAL; ready=1 only in IDLE.
REQ-012 The block SHALL capture cipherIn and keyIn on the edge where start=1 and ready=1, then enter KEXP with round counter=1.
REQ-013 KEXP: each cycle applies one forward key-schedule step (Rcon[counter]); at the 10th step keyReg=rk10 and dataReg=cipherIn^rk10; go to ROUND with counter=9.
REQ-014 ROUND: each cycle derives rk[counter] from keyReg by inverse key schedule (combinational), registers it, and sets dataReg=InvMixColumns(InvSubBytes(InvShiftRows(dataReg))^rk[counter]); counter decrements; after counter=1 go to FINAL.
REQ-015 FINAL: plainOut=InvSubBytes(InvShiftRows(dataReg))^rk0; valid=1 on the following cycle; return to IDLE.
REQ-016 Latency from accepting edge to valid high SHALL be exactly 21 cycles (10 KEXP + 9 ROUND + 1 FINAL + 1 output register).
REQ-017 valid and ready SHALL both be 1 in the cycle after FINAL; a start then is accepted (back-to-back allowed).
REQ-018 start while ready=0 SHALL be ignored; cipherIn/keyIn changes while busy SHALL NOT affect the result.
REQ-019 Inverse S-box and inverse MixColumns SHALL be GF(2^8) exact per FIPS-197; forward S-box SHALL be used in key schedule steps.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, counter=0, keyReg=0, dataReg=0, plainOut=0, valid=0; ready=1 after reset release.
REQ-021 Reset mid-operation SHALL abort with no valid pulse; first start after release SHALL complete normally.

Configuration
REQ-022 Macro KEY_CACHE_EN SHALL, when defined, add a cached copy of the last keyIn and its rk10 plus a cache-valid flag.
REQ-023 With KEY_CACHE_EN: if cache valid and keyIn equals the cached key at acceptance, KEXP SHALL be skipped (keyReg=cached rk10, dataReg=cipherIn^rk10 on the accepting edge), latency 11 cycles; otherwise 21 cycles and the cache updates at end of KEXP.
REQ-024 With KEY_CACHE_EN: reset SHALL clear the cache-valid flag.
REQ-025 Without KEY_CACHE_EN: no cache storage; latency always 21.

Verification
REQ-026 Key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plainOut 00112233445566778899aabbccddeeff, valid 21 cycles after accept.
REQ-027 Key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> plainOut 3243f6a8885a308d313198a2e0370734.
REQ-028 Hold start=1 continuously with two vectors -> second accepted on the valid cycle of the first; both outputs correct, no extra starts accepted while busy.
REQ-029 Drop rst_n at cycle 12 of an operation -> valid never pulses, plainOut=0, ready=1; next start gives correct result.
REQ-030 KEY_CACHE_EN defined: two decryptions with same key 000102...0f -> first latency 21, second 11, both correct; change key -> latency 21.
REQ-031 Toggle cipherIn and keyIn randomly while busy -> result matches the values captured at acceptance.
